// File: rtl/datapath_multiciclo.sv
// Multi-cycle MIPS-style datapath: ADD/SUB/AND/OR/SLT, ADDI, LW, SW.
// One instruction in flight at a time. It is accepted in IDLE, then moves
// through DECODE -> EXEC -> (MEM) -> (WB). The register file and the
// word-addressed data memory are both internal.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   instr_valid/ready  instruction handshake (ready only in IDLE)
//   instr[31:0]        op|rs|rt|rd|shamt|funct, imm = instr[15:0]
//   done, error        one-cycle completion / abort pulses
//   zf, result         registered zero flag and last result
//   dbg_addr/dbg_data  combinational register-file read port
module datapath_multiciclo #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64,
  parameter int REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              error,
  output logic              zf,
  output logic [DATA_W-1:0] result,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  state_t            state;
  instr_t            ir;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;

  // Register 0 and indices beyond the implemented file always read as zero.
  function automatic logic [DATA_W-1:0] reg_rd(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= REG_COUNT) return '0;
    return regs[idx[RW-1:0]];
  endfunction

  logic is_r, is_addi, is_lw, is_sw, funct_ok, illegal;
  always_comb begin
    is_r     = (ir.op == 6'b000000);
    is_addi  = (ir.op == 6'b001000);
    is_lw    = (ir.op == 6'b100011);
    is_sw    = (ir.op == 6'b101011);
    funct_ok = (ir.funct == 6'b100000) || (ir.funct == 6'b100010) ||
               (ir.funct == 6'b100100) || (ir.funct == 6'b100101) ||
               (ir.funct == 6'b101010);
    illegal  = !((is_r && funct_ok) || is_addi || is_lw || is_sw);
  end

  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx, alu_c;
  assign imm    = {ir.rd, ir.shamt, ir.funct};
  assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};

  always_comb begin
    alu_c = a_q + imm_sx;
    if (is_r) begin
      case (ir.funct)
        6'b100000: alu_c = a_q + b_q;
        6'b100010: alu_c = a_q - b_q;
        6'b100100: alu_c = a_q & b_q;
        6'b100101: alu_c = a_q | b_q;
        default:   alu_c = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      endcase
    end
  end

  // Address faults: misaligned, or any bit set above the memory's byte range.
  logic          mem_err;
  logic [AW-1:0] mem_idx;
  assign mem_err = (alu_q[1:0] != 2'b00) || (|alu_q[DATA_W-1:AW+2]);
  assign mem_idx = alu_q[AW+1:2];

  logic [4:0]        wb_dst;
  logic [DATA_W-1:0] wb_val;
  logic              wb_en;
  assign wb_dst = is_r ? ir.rd : ir.rt;
  assign wb_val = is_lw ? mdr_q : alu_q;
  assign wb_en  = (wb_dst != 5'd0) && (int'(wb_dst) < REG_COUNT);

  // Completion strobes are decoded from the current state so they land in the
  // final cycle of the instruction itself, not one cycle later.
  assign instr_ready = (state == S_IDLE);
  assign done  = ((state == S_DECODE) && illegal) ||
                 ((state == S_MEM) && (mem_err || is_sw)) ||
                 (state == S_WB);
  assign error = ((state == S_DECODE) && illegal) ||
                 ((state == S_MEM) && mem_err);

  assign dbg_data = reg_rd(dbg_addr);

  logic unused_shamt;
  assign unused_shamt = ^ir.shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      mdr_q  <= '0;
      zf     <= 1'b0;
      result <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i]  <= '0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) begin
          ir    <= instr_t'(instr);
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (illegal) state <= S_IDLE;
          else begin
            a_q   <= reg_rd(ir.rs);
            b_q   <= reg_rd(ir.rt);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q  <= alu_c;
          zf     <= (alu_c == '0);
          result <= alu_c;
          state  <= (is_lw || is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_err) state <= S_IDLE;
          else if (is_sw) begin
            mem[mem_idx] <= b_q;
            state        <= S_IDLE;
          end else begin
            mdr_q <= mem[mem_idx];
            state <= S_WB;
          end
        end
        S_WB: begin
          if (wb_en) regs[wb_dst[RW-1:0]] <= wb_val;
          if (is_lw) result <= mdr_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/datapath_multiciclo.md
Name: datapath_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle R-type datapath.
- Executes one 32-bit MIPS-style instruction at a time over 2–4 cycles. Supported: R-type ADD/SUB/AND/OR/SLT, ADDI, LW, SW.
- Instructions arrive through a valid/ready handshake.
- Internal state: register file, word-addressed data memory, FSM.
- Reports zero flag, last result, completion and error; has a debug register read port.

Parameters:
- DATA_W, 32, datapath/register/memory word width; legal range 16..64.
- MEM_DEPTH, 64, data memory depth in words; power of two, ≥4.
- REG_COUNT, 32, number of architectural registers; power of two, 2..32. Register 0 always reads 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr holds a valid instruction.
- instr_ready  out  1  high only in IDLE.
- instr  in  32  op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0].
- done  out  1  one-cycle pulse in the final cycle of each accepted instruction.
- error  out  1  pulses with done when the instruction is aborted.
- zf  out  1  registered zero flag of the last ALU result.
- result  out  DATA_W  registered: last ALU result, or loaded word for LW.
- dbg_addr  in  5  debug register index.
- dbg_data  out  DATA_W  combinational read of register dbg_addr.

Behaviour:
- Reset: state=IDLE; all registers, all memory words, zf, result, done, error cleared to 0. Reset overrides every other action in the same edge.
- Reset mid-instruction: abort, no done, no pending write performed; instr_ready=1 next cycle.
- Accept: on an edge with instr_valid&&instr_ready, instr is latched and state goes to DECODE. instr is ignored outside IDLE.
- DECODE: A<=R[rs], B<=R[rt]. imm is sign-extended to DATA_W.
- DECODE, illegal case: opcode not in {000000 R, 001000 ADDI, 100011 LW, 101011 SW}, or R-type funct not in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT}. Then done=error=1 in the DECODE cycle, no state change, state goes to IDLE.
- EXEC: ALUOut is computed as follows.
  - R-type: A op B.
  - ADDI/LW/SW: A+sext(imm).
  - ADD/SUB wrap modulo 2^DATA_W. SLT is a signed compare yielding 1 or 0.
  - zf<=(ALUOut==0) and result<=ALUOut; both update only in EXEC.
  - R/ADDI go to WB; LW/SW go to MEM.
- MEM: word index = ALUOut[log2(MEM_DEPTH)+1:2].
  - Error case: ALUOut[1:0]!=0, or ALUOut ≥ 4*MEM_DEPTH (unsigned). Then done=error=1, no memory or register write, state goes to IDLE.
  - SW: mem[idx]<=B; done=1; state goes to IDLE.
  - LW: MDR<=mem[idx]; state goes to WB.
- WB: destination is rd for R-type, rt for ADDI/LW. Value is ALUOut, or MDR for LW (result<=MDR for LW).
  - Writes are dropped when the destination is 0 or ≥ REG_COUNT.
  - done=1 in WB; state goes to IDLE.
- Latency, counted from the accept edge (cycle 0):
  - done in cycle 3 for R/ADDI.
  - done in cycle 3 for SW.
  - done in cycle 4 for LW.
  - done in cycle 1 for illegal instructions.
- Throughput: next instruction is accepted in the IDLE cycle following done.
- dbg_data: dbg_addr of 0 or ≥ REG_COUNT reads 0. A write in WB is visible on dbg_data the cycle after.
- done and error are 0 in every cycle not listed above.

Test Plan:
- Reset, then ADDI 0x20010005, ADDI 0x2002FFFD, ADD 0x00221820 -> R1=5, R2=DATA_W-wide -3, R3=2, zf=0. Each done occurs exactly 3 cycles after acceptance; instr_ready is low in between.
- SUB 0x00212022 -> R4=0, zf=1, result=0. Then SLT with R2<R1 -> 1.
- SW 0xAC010008, then LW 0x8C050008 -> mem[2]=5 and R5=5. SW done at cycle 3, LW done at cycle 4.
- LW 0x8C050006 (misaligned), and LW with offset 4*MEM_DEPTH -> done=error=1 in the MEM cycle; R5 unchanged at 5.
- Opcode 0x3F and R-type funct 0x3F -> done=error=1 in cycle 1, no register change. ADDI to R0 -> dbg R0 stays 0.
- Assert rst during EXEC of ADD -> no done, R3 reads 0, instr_ready=1 the cycle after rst drops. instr_valid held high outside IDLE is ignored.
